// File: rtl/adc_stream_framer.sv
// AD9643 two-channel sample framer: packs sign-extended sample pairs into fixed-length
// AXI4-Stream packets through a small first-word-fall-through FIFO, counts overflow drops
// and reports registered overrange pulses.
module adc_stream_framer #(
   parameter int unsigned ADC_WIDTH  = 14,
   parameter int unsigned PKT_LEN    = 256,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                 s_axi_aclk,
   input  logic                 s_axi_aresetn,
   input  logic                 data_en,
   input  logic                 adc_valid,
   input  logic [ADC_WIDTH-1:0] adc_data_a,
   input  logic [ADC_WIDTH-1:0] adc_data_b,
   input  logic                 adc_or_a,
   input  logic                 adc_or_b,
   output logic [1:0]           adc_or_state,
   output logic [31:0]          m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic                 drop_pulse,
   output logic [15:0]          drop_cnt
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned BW = $clog2(PKT_LEN);
   localparam logic [BW-1:0] LastBeat = BW'(PKT_LEN - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [BW-1:0] beat_cnt_q, beat_cnt_d;
   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic [32:0]   mem_q [FIFO_DEPTH];
   logic          drop_pulse_q;
   logic [15:0]   drop_cnt_q, drop_cnt_d;
   logic [1:0]    or_state_q;

   logic          active, full, empty, push, pop, drop, is_last, clr_drops;
   logic [15:0]   sext_a, sext_b;
   logic [32:0]   head;

   assign active  = (state_q == StRun) || (state_q == StDrain);
   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   // Full is judged before any same-cycle pop, so a push at full is always dropped.
   assign push    = adc_valid & active & ~full;
   assign drop    = adc_valid & active & full;
   assign pop     = ~empty & m_axis_tready;
   assign is_last = (beat_cnt_q == LastBeat);

   assign sext_a  = 16'($signed(adc_data_a));
   assign sext_b  = 16'($signed(adc_data_b));

   // Next-state, beat counter and drop-counter logic
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      clr_drops  = 1'b0;
      if (push) begin
         beat_cnt_d = is_last ? '0 : beat_cnt_q + 1'b1;
      end
      case (state_q)
         StIdle: begin
            if (data_en) begin
               state_d    = StRun;
               beat_cnt_d = '0;
               clr_drops  = 1'b1;
            end
         end
         StRun: begin
            // Use the post-push count so a sample accepted this cycle is never orphaned.
            if (!data_en) begin
               state_d = (beat_cnt_d == '0) ? StIdle : StDrain;
            end
         end
         StDrain: begin
            if (push && is_last) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      drop_cnt_d = drop_cnt_q;
      if (clr_drops) begin
         drop_cnt_d = '0;
      end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   // Control state, FIFO pointers and status registers
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q      <= StIdle;
         beat_cnt_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         drop_pulse_q <= 1'b0;
         drop_cnt_q   <= '0;
         or_state_q   <= '0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         drop_pulse_q <= drop;
         drop_cnt_q   <= drop_cnt_d;
         or_state_q   <= {adc_valid & adc_or_a, adc_valid & adc_or_b};
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // FIFO storage; contents are don't-care until written, reset only clears the pointers
   always_ff @(posedge s_axi_aclk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {is_last, sext_b, sext_a};
      end
   end

   // Head entry is masked while empty so the stream outputs read zero after reset
   always_comb begin
      head = mem_q[rd_ptr_q[AW-1:0]];
      if (empty) begin
         head = '0;
      end
   end

   assign m_axis_tvalid = ~empty;
   assign m_axis_tlast  = head[32];
   assign m_axis_tdata  = head[31:0];
   assign drop_pulse    = drop_pulse_q;
   assign drop_cnt      = drop_cnt_q;
   assign adc_or_state  = or_state_q;

endmodule
